// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the result producers, the write-back arbiter and the PRF / active list.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PREG_WIDTH      = 6,
  parameter int unsigned FREE_LIST_WIDTH = 3
);
  // Requester side
  logic [2:0]                 req_valid;
  logic [2:0]                 req_ready;
  logic [DATA_WIDTH-1:0]      wdata_p0;
  logic [DATA_WIDTH-1:0]      wdata_p1;
  logic [DATA_WIDTH-1:0]      wdata_p2;
  logic [PREG_WIDTH-1:0]      paddr_p0;
  logic [PREG_WIDTH-1:0]      paddr_p1;
  logic [PREG_WIDTH-1:0]      paddr_p2;
  logic [FREE_LIST_WIDTH-1:0] alidx_p0;
  logic [FREE_LIST_WIDTH-1:0] alidx_p1;
  logic [FREE_LIST_WIDTH-1:0] alidx_p2;

  // PRF write port / active-list completion side
  logic                       prf_we;
  logic [PREG_WIDTH-1:0]      prf_waddr;
  logic [DATA_WIDTH-1:0]      prf_wdata;
  logic                       al_done;
  logic [FREE_LIST_WIDTH-1:0] al_index;
  logic [1:0]                 last_grant;

  modport slave (
    input  req_valid, wdata_p0, wdata_p1, wdata_p2,
    input  paddr_p0, paddr_p1, paddr_p2, alidx_p0, alidx_p1, alidx_p2,
    output req_ready, prf_we, prf_waddr, prf_wdata, al_done, al_index, last_grant
  );

  modport master (
    output req_valid, wdata_p0, wdata_p1, wdata_p2,
    output paddr_p0, paddr_p1, paddr_p2, alidx_p0, alidx_p1, alidx_p2,
    input  req_ready, prf_we, prf_waddr, prf_wdata, al_done, al_index, last_grant
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the single PRF write port between three result producers
// (MEM/WB register, mul/div unit, load-miss return). The winner is registered for one cycle
// and then presented as a PRF write plus an active-list completion.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PREG_WIDTH      = 6,
  parameter int unsigned FREE_LIST_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                global_flush,
  input  logic                wb_hold,
  wb_port_arbiter_if.slave    bus
);

  logic [1:0]                 rr_ptr_q, rr_ptr_d;
  logic [1:0]                 last_grant_q;
  logic                       prf_we_q;
  logic [PREG_WIDTH-1:0]      prf_waddr_q;
  logic [DATA_WIDTH-1:0]      prf_wdata_q;
  logic [FREE_LIST_WIDTH-1:0] al_index_q;

  logic                       grant_vld;
  logic [1:0]                 grant_idx;
  logic [1:0]                 cand;
  int unsigned                cand_sum;
  logic [PREG_WIDTH-1:0]      sel_paddr;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [FREE_LIST_WIDTH-1:0] sel_alidx;

  // Pick the first valid requester starting at rr_ptr, wrapping 2 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand_sum  = 0;
    cand      = 2'd0;
    if (!global_flush && !wb_hold) begin
      for (int k = 0; k < 3; k++) begin
        cand_sum = int'(rr_ptr_q) + k;
        if (cand_sum >= 3) cand_sum = cand_sum - 3;
        cand = 2'(cand_sum);
        if (!grant_vld && bus.req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // One-hot ready to the winning requester, same cycle.
  always_comb begin
    bus.req_ready = 3'b000;
    if (grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

  // Payload mux for the winner and next round-robin pointer.
  always_comb begin
    sel_paddr = bus.paddr_p0;
    sel_wdata = bus.wdata_p0;
    sel_alidx = bus.alidx_p0;
    unique case (grant_idx)
      2'd1: begin
        sel_paddr = bus.paddr_p1;
        sel_wdata = bus.wdata_p1;
        sel_alidx = bus.alidx_p1;
      end
      2'd2: begin
        sel_paddr = bus.paddr_p2;
        sel_wdata = bus.wdata_p2;
        sel_alidx = bus.alidx_p2;
      end
      default: begin
        sel_paddr = bus.paddr_p0;
        sel_wdata = bus.wdata_p0;
        sel_alidx = bus.alidx_p0;
      end
    endcase
    rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  end

  // Output stage and pointer; flush clears the stage and pointer but keeps last_grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 2'd0;
      last_grant_q <= 2'd0;
      prf_we_q     <= 1'b0;
      prf_waddr_q  <= '0;
      prf_wdata_q  <= '0;
      al_index_q   <= '0;
    end else if (global_flush) begin
      rr_ptr_q     <= 2'd0;
      prf_we_q     <= 1'b0;
      prf_waddr_q  <= '0;
      prf_wdata_q  <= '0;
      al_index_q   <= '0;
    end else if (grant_vld) begin
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= grant_idx;
      prf_we_q     <= 1'b1;
      prf_waddr_q  <= sel_paddr;
      prf_wdata_q  <= sel_wdata;
      al_index_q   <= sel_alidx;
    end else begin
      prf_we_q     <= 1'b0;
    end
  end

  assign bus.prf_we     = prf_we_q;
  assign bus.al_done    = prf_we_q;
  assign bus.prf_waddr  = prf_waddr_q;
  assign bus.prf_wdata  = prf_wdata_q;
  assign bus.al_index   = al_index_q;
  assign bus.last_grant = last_grant_q;

endmodule
